// File: rtl/vdma_pkg.sv
// Shared VDMA definitions: frame-size width, frame-sync mode names, stream sideband payload.
package vdma_pkg;

  localparam int unsigned FRAME_W = 16;

  localparam string FS_ON  = "ON";
  localparam string FS_OFF = "OFF";

  typedef logic [FRAME_W-1:0] frame_cnt_t;

  typedef struct packed {
    logic tuser;
    logic tlast;
  } axis_side_t;

  // True when pos is the final index of a dimension of the given (non-zero) size.
  function automatic logic is_last(input frame_cnt_t pos, input frame_cnt_t size);
    return pos == (size - FRAME_W'(1));
  endfunction

endpackage

// File: rtl/stream_out_port_axis_reg.sv
// One-entry AXI4-Stream output register: load captures a beat, accept retires it.
module axis_out_reg
  import vdma_pkg::*;
#(
  parameter int unsigned DSIZE = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_ce,
  input  logic             i_load,
  input  logic [DSIZE-1:0] i_data,
  input  axis_side_t       i_side,
  input  logic             i_ready,
  output logic [DSIZE-1:0] o_data,
  output axis_side_t       o_side,
  output logic             o_valid
);

  logic [DSIZE-1:0] r_data;
  axis_side_t       r_side;
  logic             r_valid;

  // A load always wins: it either fills an empty slot or replaces a beat accepted this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_side  <= '0;
      r_valid <= 1'b0;
    end else if (i_ce) begin
      if (i_load) begin
        r_data  <= i_data;
        r_side  <= i_side;
        r_valid <= 1'b1;
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_data  = r_data;
  assign o_side  = r_side;
  assign o_valid = r_valid;

endmodule

// File: rtl/stream_out_port.sv
// VDMA read-side egress: pops the show-ahead FIFO and emits an hactive x vactive AXI4-Stream video frame.
module stream_out_port
  import vdma_pkg::*;
#(
  parameter int unsigned DSIZE      = 24,
  parameter string       FRAME_SYNC = FS_OFF
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               aclken,
  input  logic               enable,
  input  logic [FRAME_W-1:0] vactive,
  input  logic [FRAME_W-1:0] hactive,
  input  logic               fsync,
  input  logic [DSIZE-1:0]   fifo_rdata,
  input  logic               fifo_empty,
  output logic               fifo_rd_en,
  output logic [DSIZE-1:0]   axi_tdata,
  output logic               axi_tvalid,
  input  logic               axi_tready,
  output logic               axi_tuser,
  output logic               axi_tlast,
  output logic               frame_done,
  output logic               busy
);

  localparam bit FS_EN = (FRAME_SYNC == FS_ON);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_FS,
    ST_RUN,
    ST_DRAIN
  } state_t;

  state_t     r_state;
  frame_cnt_t r_h;
  frame_cnt_t r_v;
  frame_cnt_t r_x;
  frame_cnt_t r_y;
  logic       r_fsync_q;
  logic       r_frame_done;
  logic       r_busy;

  logic       w_tvalid;
  logic       w_load;
  logic       w_accept;
  logic       w_x_last;
  logic       w_y_last;
  logic       w_fs_rise;
  logic       w_arm;
  axis_side_t w_side_in;
  axis_side_t w_side_out;

  assign w_x_last  = is_last(r_x, r_h);
  assign w_y_last  = is_last(r_y, r_v);
  assign w_fs_rise = fsync & ~r_fsync_q;
  assign w_arm     = enable && (hactive != '0) && (vactive != '0);

  // The output slot can take a new pixel when empty or when its beat leaves this cycle.
  assign w_load   = aclken && (r_state == ST_RUN) && !fifo_empty && (!w_tvalid || axi_tready);
  assign w_accept = w_tvalid && axi_tready;

  assign w_side_in.tuser = (r_x == '0) && (r_y == '0);
  assign w_side_in.tlast = w_x_last;

  // Frame sequencer: arm, optional fsync gate, pixel walk, drain of the final beat.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state      <= ST_IDLE;
      r_h          <= '0;
      r_v          <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_fsync_q    <= 1'b0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
    end else if (aclken) begin
      r_fsync_q    <= fsync;
      r_frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_arm) begin
            r_h     <= hactive;
            r_v     <= vactive;
            r_x     <= '0;
            r_y     <= '0;
            r_busy  <= 1'b1;
            r_state <= FS_EN ? ST_WAIT_FS : ST_RUN;
          end
        end
        ST_WAIT_FS: begin
          if (w_fs_rise) r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (w_load) begin
            if (w_x_last) begin
              r_x <= '0;
              r_y <= r_y + FRAME_W'(1);
              if (w_y_last) r_state <= ST_DRAIN;
            end else begin
              r_x <= r_x + FRAME_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (w_accept) begin
            r_frame_done <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  axis_out_reg #(
    .DSIZE (DSIZE)
  ) u_out_reg (
    .clk     (aclk),
    .rst_n   (aresetn),
    .i_ce    (aclken),
    .i_load  (w_load),
    .i_data  (fifo_rdata),
    .i_side  (w_side_in),
    .i_ready (axi_tready),
    .o_data  (axi_tdata),
    .o_side  (w_side_out),
    .o_valid (w_tvalid)
  );

  assign fifo_rd_en = w_load;
  assign axi_tvalid = w_tvalid;
  assign axi_tuser  = w_side_out.tuser;
  assign axi_tlast  = w_side_out.tlast;
  assign frame_done = r_frame_done;
  assign busy       = r_busy;

endmodule

// File: tb/tb_stream_out_port.sv
// Directed bench for stream_out_port: FIFO model, beat log and hand-computed expected frames.
module tb_stream_out_port;

  localparam int unsigned DSIZE = 24;

  logic             aclk = 1'b0;
  logic             aresetn = 1'b0;
  logic             aclken = 1'b1;
  logic             enable = 1'b0;
  logic             enable_fs = 1'b0;
  logic             fsync = 1'b0;
  logic [15:0]      hactive = 16'd4;
  logic [15:0]      vactive = 16'd2;
  logic             axi_tready = 1'b1;
  logic             tready_fs = 1'b1;

  logic [DSIZE-1:0] mem [64];
  int               wr_ptr = 0;
  int               rd_ptr = 0;
  logic             fifo_empty;
  logic [DSIZE-1:0] fifo_rdata;
  logic [DSIZE-1:0] fs_cnt = '0;

  wire              fifo_rd_en, axi_tvalid, axi_tuser, axi_tlast, frame_done, busy;
  wire [DSIZE-1:0]  axi_tdata;
  wire              fs_rd_en, fs_tvalid, fs_tuser, fs_tlast, fs_done, fs_busy;
  wire [DSIZE-1:0]  fs_tdata;

  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_rdata = mem[rd_ptr % 64];

  always #5 aclk = ~aclk;

  always @(posedge aclk) if (fifo_rd_en) rd_ptr <= rd_ptr + 1;
  always @(posedge aclk) if (fs_rd_en) fs_cnt <= fs_cnt + 1'b1;

  stream_out_port #(.DSIZE(DSIZE), .FRAME_SYNC("OFF")) u_dut (
    .aclk(aclk), .aresetn(aresetn), .aclken(aclken), .enable(enable),
    .vactive(vactive), .hactive(hactive), .fsync(fsync),
    .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .axi_tdata(axi_tdata), .axi_tvalid(axi_tvalid), .axi_tready(axi_tready),
    .axi_tuser(axi_tuser), .axi_tlast(axi_tlast), .frame_done(frame_done), .busy(busy)
  );

  stream_out_port #(.DSIZE(DSIZE), .FRAME_SYNC("ON")) u_dut_fs (
    .aclk(aclk), .aresetn(aresetn), .aclken(aclken), .enable(enable_fs),
    .vactive(vactive), .hactive(hactive), .fsync(fsync),
    .fifo_rdata(fs_cnt), .fifo_empty(1'b0), .fifo_rd_en(fs_rd_en),
    .axi_tdata(fs_tdata), .axi_tvalid(fs_tvalid), .axi_tready(tready_fs),
    .axi_tuser(fs_tuser), .axi_tlast(fs_tlast), .frame_done(fs_done), .busy(fs_busy)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [DSIZE-1:0] bd [16];
  logic             bu [16];
  logic             bl [16];
  int               bc [16];
  int               nb, n_pop, n_done, done_cyc, n_hold, tr_mode;
  int               cyc = 0;

  task automatic clear_log();
    nb = 0; n_pop = 0; n_done = 0; done_cyc = -1; n_hold = 0;
  endtask

  task automatic push(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr % 64] = DSIZE'(base + i);
      wr_ptr++;
    end
  endtask

  // One clock: log the beat leaving at the coming edge, then check stalled beats stayed put.
  task automatic tick();
    logic             held;
    logic [DSIZE+1:0] hv;
    #1;
    held = aclken && axi_tvalid && !axi_tready;
    hv   = {axi_tdata, axi_tuser, axi_tlast};
    if (aclken && axi_tvalid && axi_tready && nb < 16) begin
      bd[nb] = axi_tdata; bu[nb] = axi_tuser; bl[nb] = axi_tlast; bc[nb] = cyc;
      nb++;
    end
    if (fifo_rd_en) n_pop++;
    @(posedge aclk);
    #1;
    cyc++;
    if (frame_done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (held) begin
      n_hold++;
      check("stall_hold", 32'({axi_tvalid, axi_tdata, axi_tuser, axi_tlast}), 32'({1'b1, hv}));
    end
    axi_tready = (tr_mode == 1) ? cyc[0] : 1'b1;
  endtask

  task automatic arm();
    enable = 1'b1;
    tick();
    enable = 1'b0;
  endtask

  task automatic run_to_done(input int budget);
    for (int k = 0; k < budget && n_done == 0; k++) tick();
  endtask

  task automatic check_frame(input string tag, input int base);
    check({tag, "_nbeats"}, 32'(nb), 32'd8);
    for (int i = 0; i < 8; i++)
      check({tag, "_beat"}, 32'({bd[i], bu[i], bl[i]}),
            32'({DSIZE'(base + i), (i == 0), (i == 3 || i == 7)}));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic any_a, any_b;
    tr_mode = 0;
    clear_log();
    repeat (3) @(posedge aclk);
    #1;
    check("reset_ctl", 32'({axi_tvalid, axi_tuser, axi_tlast, frame_done, busy, fifo_rd_en}), 32'd0);
    check("reset_data", 32'(axi_tdata), 32'd0);
    check("reset_fs", 32'({fs_tvalid, fs_busy, fs_rd_en}), 32'd0);
    aresetn = 1'b1;

    // 1: back-to-back frame
    push(0, 8);
    clear_log();
    arm();
    check("t1_busy", 32'(busy), 32'd1);
    run_to_done(40);
    repeat (2) tick();
    check_frame("t1", 0);
    check("t1_pops", 32'(n_pop), 32'd8);
    check("t1_b2b", 32'(bc[7] - bc[0]), 32'd7);
    check("t1_done_time", 32'(done_cyc), 32'(bc[7] + 1));
    check("t1_done_cnt", 32'(n_done), 32'd1);
    check("t1_idle", 32'({busy, axi_tvalid}), 32'd0);

    // 2: alternating tready
    push(16, 8);
    clear_log();
    tr_mode = 1;
    arm();
    run_to_done(60);
    repeat (2) tick();
    tr_mode = 0;
    check_frame("t2", 16);
    check("t2_pops", 32'(n_pop), 32'd8);
    check("t2_stalled", 32'(n_hold > 0), 32'd1);

    // 3: underrun after word 1
    push(32, 2);
    clear_log();
    arm();
    for (int k = 0; k < 40 && nb < 2; k++) tick();
    repeat (5) tick();
    check("t3_underrun", 32'({axi_tvalid, busy}), 32'b01);
    check("t3_nb", 32'(nb), 32'd2);
    push(34, 6);
    run_to_done(40);
    repeat (2) tick();
    check_frame("t3", 32);
    check("t3_pops", 32'(n_pop), 32'd8);

    // 4: fsync gating
    enable_fs = 1'b1;
    tick();
    enable_fs = 1'b0;
    any_a = 1'b0;
    repeat (20) begin
      tick();
      any_a = any_a | fs_tvalid | fs_rd_en;
    end
    check("t4_gated", 32'(any_a), 32'd0);
    check("t4_busy", 32'(fs_busy), 32'd1);
    fsync = 1'b1;
    tick();
    check("t4_rise_edge", 32'(fs_tvalid), 32'd0);
    tick();
    check("t4_first", 32'({fs_tvalid, fs_tuser, fs_tdata}), 32'({2'b11, DSIZE'(0)}));
    fsync = 1'b0;
    repeat (12) tick();
    check("t4_end", 32'({fs_busy, fs_tvalid}), 32'd0);

    // 5: reset mid-frame
    push(48, 8);
    clear_log();
    arm();
    for (int k = 0; k < 20 && nb < 2; k++) tick();
    check("t5_beat2", 32'({axi_tvalid, axi_tdata}), 32'({1'b1, DSIZE'(50)}));
    aresetn = 1'b0;
    #1;
    check("t5_rst_ctl", 32'({axi_tvalid, axi_tuser, axi_tlast, frame_done, busy, fifo_rd_en}), 32'd0);
    check("t5_rst_data", 32'(axi_tdata), 32'd0);
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    clear_log();
    arm();
    for (int k = 0; k < 20 && nb < 1; k++) tick();
    check("t5_restart", 32'({bd[0], bu[0]}), 32'({DSIZE'(51), 1'b1}));
    push(56, 3);
    run_to_done(40);
    repeat (2) tick();
    check_frame("t5", 51);

    // aclken freeze
    push(64, 8);
    clear_log();
    arm();
    tick();
    aclken = 1'b0;
    #1;
    check("ce_rd_en", 32'(fifo_rd_en), 32'd0);
    repeat (3) tick();
    check("ce_hold", 32'({axi_tvalid, axi_tuser, axi_tdata}), 32'({2'b11, DSIZE'(64)}));
    check("ce_nb", 32'(nb), 32'd0);
    aclken = 1'b1;
    run_to_done(40);
    repeat (2) tick();
    check_frame("ce", 64);

    // 6: zero-size frames never start
    hactive = 16'd0;
    vactive = 16'd2;
    enable = 1'b1;
    any_a = 1'b0;
    any_b = 1'b0;
    repeat (100) begin
      tick();
      any_a = any_a | fifo_rd_en;
      any_b = any_b | busy;
    end
    check("t6_h0", 32'({any_a, any_b}), 32'd0);
    hactive = 16'd4;
    vactive = 16'd0;
    repeat (10) begin
      tick();
      any_a = any_a | fifo_rd_en | axi_tvalid;
      any_b = any_b | busy;
    end
    check("t6_v0", 32'({any_a, any_b}), 32'd0);
    enable = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
